// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared encodings and MEM/WB control record for the write-back stage
package wb_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_H  = 3'd1;
    localparam logic [2:0] LD_HU = 3'd2;
    localparam logic [2:0] LD_B  = 3'd3;
    localparam logic [2:0] LD_BU = 3'd4;

    // Width-independent MEM/WB fields; the datapath-wide fields live beside it in the stage.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [2:0] load_type;
        logic [1:0] byte_off;
    } memwb_ctrl_t;

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - sub-word load alignment with sign/zero extension
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] raw_i,
    input  logic [2:0]        load_type_i,
    input  logic [1:0]        byte_off_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw_i[{byte_off_i, 3'b000} +: 8];
        // Halfword selection uses only the upper offset bit; misaligned halves are not split.
        half_sel = raw_i[{byte_off_i[1], 4'b0000} +: 16];
        case (load_type_i)
            LD_H:    data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LD_HU:   data_o = {{(DATA_W-16){1'b0}}, half_sel};
            LD_B:    data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_BU:   data_o = {{(DATA_W-8){1'b0}}, byte_sel};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/wb_stage_ext.sv
// rtl/wb_stage_ext.sv - MEM/WB register, result select and retire counter
// Sub-word load alignment is built only when WB_SUBWORD_LOAD_EN is defined.
module wb_stage_ext
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic              RegWrite_i,
    input  logic [1:0]        wb_sel_i,
    input  logic [2:0]        load_type_i,
    input  logic [1:0]        byte_off_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [DATA_W-1:0] ALU_result_i,
    input  logic [DATA_W-1:0] link_addr_i,
    input  logic [REG_AW-1:0] dest_reg_i,
    output logic              WB_RegWrite_o,
    output logic [REG_AW-1:0] WB_WriteAddr_o,
    output logic [DATA_W-1:0] WB_WriteData_o,
    output logic              WB_Valid_o,
    output logic [CNT_W-1:0]  retire_cnt_o
);

    memwb_ctrl_t       ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] link_q, link_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] load_data;

    always_comb begin
        ctrl_d  = ctrl_q;
        rdata_d = rdata_q;
        alu_d   = alu_q;
        link_d  = link_q;
        dest_d  = dest_q;
        cnt_d   = cnt_q;
        // An instruction retires when it leaves WB, i.e. on any unstalled edge.
        if (ctrl_q.valid && !stall_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (flush_i) begin
            ctrl_d = '0;
        end else if (!stall_i) begin
            ctrl_d.valid     = valid_i;
            ctrl_d.reg_write = RegWrite_i;
            ctrl_d.wb_sel    = wb_sel_i;
            ctrl_d.load_type = load_type_i;
            ctrl_d.byte_off  = byte_off_i;
            rdata_d          = read_data_i;
            alu_d            = ALU_result_i;
            link_d           = link_addr_i;
            dest_d           = dest_reg_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q  <= '0;
            rdata_q <= '0;
            alu_q   <= '0;
            link_q  <= '0;
            dest_q  <= '0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            link_q  <= link_d;
            dest_q  <= dest_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef WB_SUBWORD_LOAD_EN
    wb_load_align #(
        .DATA_W(DATA_W)
    ) u_load_align (
        .raw_i       (rdata_q),
        .load_type_i (ctrl_q.load_type),
        .byte_off_i  (ctrl_q.byte_off),
        .data_o      (load_data)
    );
`else
    logic unused_ld_fields;
    assign unused_ld_fields = ^{ctrl_q.load_type, ctrl_q.byte_off};
    assign load_data        = rdata_q;
`endif

    always_comb begin
        case (ctrl_q.wb_sel)
            WB_SEL_MEM:  WB_WriteData_o = load_data;
            WB_SEL_LINK: WB_WriteData_o = link_q;
            default:     WB_WriteData_o = alu_q;
        endcase
    end

    assign WB_RegWrite_o  = ctrl_q.valid & ctrl_q.reg_write & (dest_q != '0);
    assign WB_WriteAddr_o = dest_q;
    assign WB_Valid_o     = ctrl_q.valid;
    assign retire_cnt_o   = cnt_q;

endmodule

// File: tb/tb_wb_stage_ext.sv
// tb/tb_wb_stage_ext.sv - scoreboard bench for wb_stage_ext, default and narrow-counter instances
module tb_wb_stage_ext;
    import wb_pkg::*;

`ifdef WB_SUBWORD_LOAD_EN
    localparam bit SUBW = 1'b1;
`else
    localparam bit SUBW = 1'b0;
`endif
    localparam logic [31:0] RD_WORD = 32'h80FF_7F01;
    localparam logic [31:0] LINK    = 32'h0040_0008;

    logic        clk_i = 1'b0;
    logic        rst_i, stall_i, flush_i, valid_i, RegWrite_i;
    logic [1:0]  wb_sel_i, byte_off_i;
    logic [2:0]  load_type_i;
    logic [31:0] read_data_i, ALU_result_i, link_addr_i;
    logic [4:0]  dest_reg_i;
    logic        WB_RegWrite_o, WB_Valid_o;
    logic [4:0]  WB_WriteAddr_o;
    logic [31:0] WB_WriteData_o, retire_cnt_o;
    logic        w_regwrite, w_valid;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_cnt;

    always #5 clk_i = ~clk_i;

    wb_stage_ext dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .RegWrite_i(RegWrite_i), .wb_sel_i(wb_sel_i),
        .load_type_i(load_type_i), .byte_off_i(byte_off_i), .read_data_i(read_data_i),
        .ALU_result_i(ALU_result_i), .link_addr_i(link_addr_i), .dest_reg_i(dest_reg_i),
        .WB_RegWrite_o(WB_RegWrite_o), .WB_WriteAddr_o(WB_WriteAddr_o),
        .WB_WriteData_o(WB_WriteData_o), .WB_Valid_o(WB_Valid_o), .retire_cnt_o(retire_cnt_o)
    );

    wb_stage_ext #(.CNT_W(4)) dut_w (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .RegWrite_i(RegWrite_i), .wb_sel_i(wb_sel_i),
        .load_type_i(load_type_i), .byte_off_i(byte_off_i), .read_data_i(read_data_i),
        .ALU_result_i(ALU_result_i), .link_addr_i(link_addr_i), .dest_reg_i(dest_reg_i),
        .WB_RegWrite_o(w_regwrite), .WB_WriteAddr_o(w_addr),
        .WB_WriteData_o(w_data), .WB_Valid_o(w_valid), .retire_cnt_o(w_cnt)
    );

    typedef struct {
        logic        v;
        logic        rw;
        logic [4:0]  a;
        logic [31:0] d;
        logic        chk_d;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_asrt = 0;
    int          n_fail = 0;
    logic        m_v, m_rw, m_chk;
    logic [4:0]  m_a;
    logic [31:0] m_d, m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge(input string tag);
        exp_t e;
        e.v = m_v; e.rw = m_v & m_rw & (m_a != 5'd0); e.a = m_a;
        e.d = m_d; e.chk_d = m_chk; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk_i);
        @(negedge clk_i);
        e = sb.pop_front();
        chk({tag, ":valid"}, 32'(WB_Valid_o), 32'(e.v));
        chk({tag, ":regwrite"}, 32'(WB_RegWrite_o), 32'(e.rw));
        if (e.chk_d) begin
            chk({tag, ":addr"}, 32'(WB_WriteAddr_o), 32'(e.a));
            chk({tag, ":data"}, WB_WriteData_o, e.d);
        end
        chk({tag, ":cnt"}, retire_cnt_o, e.cnt);
        chk({tag, ":cnt4"}, 32'(w_cnt), 32'(e.cnt[3:0]));
    endtask

    task automatic step(input logic st, input logic fl, input logic v, input logic rw,
                        input logic [1:0] sel, input logic [2:0] lt, input logic [1:0] off,
                        input logic [31:0] alu, input logic [4:0] dst,
                        input logic [31:0] exp_d, input string tag);
        rst_i = 1'b0; stall_i = st; flush_i = fl; valid_i = v; RegWrite_i = rw;
        wb_sel_i = sel; load_type_i = lt; byte_off_i = off; read_data_i = RD_WORD;
        ALU_result_i = alu; link_addr_i = LINK; dest_reg_i = dst;
        if (m_v && !st) m_cnt = m_cnt + 32'd1;
        if (fl) begin
            m_v = 1'b0; m_rw = 1'b0; m_chk = 1'b0;
        end else if (!st) begin
            m_v = v; m_rw = rw; m_a = dst; m_d = exp_d; m_chk = 1'b1;
        end
        drive_edge(tag);
    endtask

    task automatic do_reset(input logic st, input string tag);
        rst_i = 1'b1; stall_i = st; flush_i = 1'b0; valid_i = 1'b1; RegWrite_i = 1'b1;
        m_v = 1'b0; m_rw = 1'b0; m_a = 5'd0; m_d = 32'd0; m_chk = 1'b1; m_cnt = 32'd0;
        drive_edge(tag);
        rst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; RegWrite_i = 1'b0;
        wb_sel_i = 2'b00; load_type_i = 3'd0; byte_off_i = 2'd0; read_data_i = '0;
        ALU_result_i = '0; link_addr_i = '0; dest_reg_i = '0;
        do_reset(1'b0, "reset0");
        do_reset(1'b0, "reset1");

        step(0, 0, 1, 1, WB_SEL_ALU, LD_W, 2'd0, 32'h0000_1234, 5'd5, 32'h0000_1234, "alu");
        step(0, 0, 1, 1, WB_SEL_MEM, LD_B, 2'd3, 32'h1, 5'd6,
             SUBW ? 32'hFFFF_FF80 : RD_WORD, "lb3");
        step(0, 0, 1, 1, WB_SEL_MEM, LD_BU, 2'd3, 32'h2, 5'd7,
             SUBW ? 32'h0000_0080 : RD_WORD, "lbu3");
        step(0, 0, 1, 1, WB_SEL_MEM, LD_H, 2'd2, 32'h3, 5'd8,
             SUBW ? 32'hFFFF_80FF : RD_WORD, "lh2");
        step(0, 0, 1, 1, WB_SEL_MEM, LD_HU, 2'd0, 32'h4, 5'd9,
             SUBW ? 32'h0000_7F01 : RD_WORD, "lhu0");
        step(0, 0, 1, 1, WB_SEL_MEM, LD_H, 2'd3, 32'h5, 5'd10,
             SUBW ? 32'hFFFF_80FF : RD_WORD, "lh3");
        step(0, 0, 1, 1, WB_SEL_MEM, LD_W, 2'd1, 32'h6, 5'd11, RD_WORD, "lw");
        step(0, 0, 1, 1, WB_SEL_LINK, LD_W, 2'd0, 32'h7, 5'd31, LINK, "link");
        step(0, 0, 1, 1, 2'b11, LD_W, 2'd0, 32'hABCD_0011, 5'd12, 32'hABCD_0011, "sel11");
        step(0, 0, 1, 1, WB_SEL_ALU, LD_W, 2'd0, 32'h0000_0099, 5'd0, 32'h0000_0099, "dest0");
        step(0, 0, 1, 0, WB_SEL_ALU, LD_W, 2'd0, 32'h0000_0077, 5'd13, 32'h0000_0077, "norw");

        step(0, 0, 1, 1, WB_SEL_ALU, LD_W, 2'd0, 32'h0000_CAFE, 5'd14, 32'h0000_CAFE, "stall_cap");
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, WB_SEL_LINK, LD_B, 2'd1, 32'hDEAD_BEEF, 5'd3, 32'd0, "stall_hold");
        step(0, 0, 1, 1, WB_SEL_ALU, LD_W, 2'd0, 32'h0000_0042, 5'd15, 32'h0000_0042, "stall_rel");

        step(1, 1, 1, 1, WB_SEL_ALU, LD_W, 2'd0, 32'h0000_0055, 5'd16, 32'd0, "stall_flush");
        step(0, 0, 0, 1, WB_SEL_ALU, LD_W, 2'd0, 32'h0000_0066, 5'd17, 32'h0000_0066, "bubble_in");
        step(0, 0, 1, 1, WB_SEL_ALU, LD_W, 2'd0, 32'h0000_0088, 5'd18, 32'h0000_0088, "pre_flush");
        step(0, 1, 1, 1, WB_SEL_ALU, LD_W, 2'd0, 32'h0000_0111, 5'd19, 32'd0, "flush");

        step(0, 0, 1, 1, WB_SEL_ALU, LD_W, 2'd0, 32'h0000_0222, 5'd20, 32'h0000_0222, "pre_rst");
        step(1, 0, 1, 1, WB_SEL_ALU, LD_W, 2'd0, 32'h0000_0333, 5'd21, 32'd0, "pre_rst_stall");
        do_reset(1'b1, "rst_in_stall");

        for (int i = 0; i < 17; i++)
            step(0, 0, 1, 1, WB_SEL_ALU, LD_W, 2'd0, 32'(i + 100), 5'd1, 32'(i + 100), "wrap_run");
        chk("wrap_narrow", 32'(w_cnt), 32'd0);
        chk("wrap_wide", retire_cnt_o, 32'd16);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage_ext.md
# wb_stage_ext

Parametrised write-back stage with an integrated MEM/WB pipeline register. It captures MEM-stage results, supports stall and flush control, and selects among ALU result, load data and link address. Sub-word loads are aligned and sign- or zero-extended before write-back. It drives the register-file write port and forwarding unit, and keeps a retired-instruction counter for the performance block.

## Interface
Parameters:
- DATA_W, 32, datapath width; must be 32 when sub-word loads are enabled
- REG_AW, 5, register index width
- CNT_W, 32, retire counter width

Ports. One clock; reset is synchronous and active-high.
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- stall_i  in  1  hold MEM/WB register contents
- flush_i  in  1  load a bubble into MEM/WB
- valid_i  in  1  MEM stage holds a real instruction
- RegWrite_i  in  1  instruction writes the register file
- wb_sel_i  in  2  result source: ALU, MEM or LINK
- load_type_i  in  3  LW, LH, LHU, LB or LBU
- byte_off_i  in  2  ALU_result[1:0] of the load address
- read_data_i  in  DATA_W  raw memory word
- ALU_result_i  in  DATA_W  ALU result
- link_addr_i  in  DATA_W  PC+8 for JAL/JALR
- dest_reg_i  in  REG_AW  destination register
- WB_RegWrite_o  out  1  register-file write enable, also to forwarding
- WB_WriteAddr_o  out  REG_AW  write index
- WB_WriteData_o  out  DATA_W  write data, also to the ALU forwarding mux
- WB_Valid_o  out  1  a real instruction occupies WB this cycle
- retire_cnt_o  out  CNT_W  count of retired instructions

## Operation
- The MEM/WB register captures all `*_i` fields on each rising edge when stall_i=0 and flush_i=0.
- flush_i=1 clears the valid and RegWrite bits. Data fields are don't-care.
- flush_i takes priority over stall_i when both are asserted.
- stall_i=1 with flush_i=0 holds every field, including the valid bit.
- Source select from the registered wb_sel:
  - 00: ALU result
  - 01: aligned load data
  - 10: link address
  - 11: reserved, treated as ALU
- Load alignment, from the registered load_type and byte_off:
  - LW: word unchanged
  - LH/LHU: halfword at byte_off[1]; byte_off[0] is ignored
  - LB/LBU: byte at byte_off
  - LH and LB sign-extend; LHU and LBU zero-extend.
- WB_RegWrite_o = reg_valid & reg_RegWrite & (reg_dest != 0). A write to $0 is always suppressed.
- WB_WriteAddr_o and WB_WriteData_o are combinational from the register and driven every cycle.
- WB_Valid_o = reg_valid.
- retire_cnt_o increments by 1 on each rising edge where WB_Valid_o=1 and stall_i=0. A stalled instruction is counted once, when it leaves WB.
- The counter wraps from 2^CNT_W-1 to 0.

## Timing
- Latency: inputs sampled at edge N appear on outputs during cycle N+1.
- Reset values:
  - All register fields are 0.
  - WB_RegWrite_o=0, WB_Valid_o=0, WB_WriteAddr_o=0, WB_WriteData_o=0, retire_cnt_o=0.
- rst_i has priority over stall_i and flush_i. Reset mid-stall discards the held instruction, which is not counted.
- There is no combinational path from any `*_i` input to any output.
- Same-cycle write/read ordering against the register file is resolved in the register file, not here.

## Configuration
- WB_SUBWORD_LOAD_EN
  - Defined: the full LB/LBU/LH/LHU/LW alignment and extension above.
  - Undefined: load_type_i and byte_off_i are ignored and the load path passes read_data_i unchanged, as LW. The alignment sub-module is not instantiated.

## Structure
- Shared package wb_pkg holds:
  - the wb_sel encodings: WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_LINK=2'b10
  - the load_type encodings: LD_W=3'd0, LD_H=3'd1, LD_HU=3'd2, LD_B=3'd3, LD_BU=3'd4
  - a packed struct type for the MEM/WB register fields
- Sub-module wb_load_align: combinational; inputs raw word, load_type and byte_off; output is the extended word.

## Test plan
- Reset, then valid_i=1, RegWrite_i=1, wb_sel=ALU, ALU_result=0x0000_1234, dest=5 → next cycle WB_RegWrite_o=1, addr=5, data=0x0000_1234; retire_cnt_o=1 one edge later.
- Loads with read_data=0x80FF_7F01:
  - LB, off=3 → 0xFFFF_FF80
  - LBU, off=3 → 0x0000_0080
  - LH, off=2 → 0xFFFF_80FF
  - LHU, off=0 → 0x0000_7F01
- dest=0 with RegWrite_i=1 → WB_RegWrite_o=0, WB_Valid_o=1, and the counter still increments.
- stall_i=1 for 3 cycles on a held instruction → outputs constant and the counter increments exactly once, after the stall releases.
- stall_i=1 and flush_i=1 together → bubble: WB_Valid_o=0, WB_RegWrite_o=0, no count.
- Preload the counter to 0xFFFF_FFFF, then retire one instruction → retire_cnt_o=0. Separately, assert rst_i during a stall → all outputs 0 on the next cycle.
